// File: rtl/instruction_fetch.sv
// Fetch stage between the PC register and IF/ID: one outstanding imem request,
// a one-entry hold buffer for downstream stalls, and flush-driven discard.
module instruction_fetch #(
    parameter int INST_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              pcEnable_o,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INST_W-1:0] imem_data_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] req_addr;
    logic              drop;
    logic              hb_valid;
    logic [INST_W-1:0] hb_inst;
    logic [ADDR_W-1:0] hb_pc;

    logic ack_ok;
    logic out_held;
    logic park;
    logic capture;

    // An ack is only accepted when nothing has marked the request as stale.
    assign ack_ok   = (state == REQ) && imem_ack_i && !drop && !flush_i;
    assign out_held = stall_i && inst_valid_o;
    assign park     = ack_ok && out_held;
    assign capture  = (state == IDLE) && start_i && !flush_i;

    assign imem_addr_o = req_addr;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (capture) state_nxt = REQ;
            end
            REQ: begin
                if (imem_ack_i) state_nxt = park ? HOLD : IDLE;
            end
            HOLD: begin
                if (!stall_i || flush_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // pcEnable is forced low while reset is asserted, even if flush is high.
    always_comb begin
        imem_req_o = (state == REQ);
        pcEnable_o = rst_i && (ack_ok || flush_i);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            req_addr     <= '0;
            drop         <= 1'b0;
            hb_valid     <= 1'b0;
            hb_inst      <= '0;
            hb_pc        <= '0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
            inst_valid_o <= 1'b0;
        end else begin
            if (capture) req_addr <= pc_i;

            // A flush during an outstanding request poisons its eventual ack.
            if (state == REQ) drop <= imem_ack_i ? 1'b0 : (drop | flush_i);

            if (park) begin
                hb_inst <= imem_data_i;
                hb_pc   <= req_addr;
            end

            if (flush_i) begin
                inst_valid_o <= 1'b0;
                hb_valid     <= 1'b0;
            end else if (out_held) begin
                hb_valid <= hb_valid | park;
            end else if (hb_valid) begin
                inst_o       <= hb_inst;
                inst_pc_o    <= hb_pc;
                inst_valid_o <= 1'b1;
                hb_valid     <= 1'b0;
            end else if (ack_ok) begin
                inst_o       <= imem_data_i;
                inst_pc_o    <= req_addr;
                inst_valid_o <= 1'b1;
            end else begin
                inst_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: PC-register and memory models, a delivery
// scoreboard, a table-driven fetch stream and hand-written corner sequences.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic [31:0] pc_i;
    logic        stall_i;
    logic        flush_i;
    logic        pcEnable_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;

    instruction_fetch #(.INST_W(32), .ADDR_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .pc_i         (pc_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .pcEnable_o   (pcEnable_o),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    vec_t        vecs [6];
    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          pe_total = 0;
    int          v_total = 0;
    int          mcnt = 0;
    logic [31:0] target = 32'h0;
    logic        s_req, s_pe, s_valid;
    logic [31:0] s_addr, s_inst, s_pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Memory contents/latency: table entries, otherwise a recognisable default.
    function automatic void lookup(input logic [31:0] a, output logic [31:0] d, output int l);
        d = 32'hDEAD_0000 | {16'h0, a[15:0]};
        l = 3;
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].pc == a) begin
                d = vecs[i].inst;
                l = vecs[i].lat;
            end
        end
    endfunction

    task automatic tick();
        logic        fl_s;
        logic [31:0] d;
        int          l;
        exp_t        e;
        @(negedge clk);
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        s_pe    = pcEnable_o;
        s_valid = inst_valid_o;
        s_inst  = inst_o;
        s_pc    = inst_pc_o;
        fl_s    = flush_i;
        if (s_pe) pe_total++;
        if (s_valid) v_total++;
        if (inst_valid_o && (!stall_i || flush_i)) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_delivery: got inst %h pc %h required none", inst_o, inst_pc_o);
            end else begin
                e = sb.pop_front();
                chk("deliver_inst", inst_o, e.inst);
                chk("deliver_pc", inst_pc_o, e.pc);
            end
        end
        @(posedge clk);
        #1;
        if (s_pe) pc_i = fl_s ? target : pc_i + 32'd4;
        if (imem_req_o) begin
            mcnt++;
            lookup(imem_addr_o, d, l);
            imem_ack_i  = (mcnt == l);
            imem_data_i = imem_ack_i ? d : 32'h0;
        end else begin
            mcnt        = 0;
            imem_ack_i  = 1'b0;
            imem_data_i = 32'h0;
        end
    endtask

    task automatic do_reset(input logic [31:0] pc0);
        rst_i       = 1'b0;
        start_i     = 1'b0;
        stall_i     = 1'b0;
        flush_i     = 1'b0;
        imem_ack_i  = 1'b0;
        imem_data_i = 32'h0;
        mcnt        = 0;
        pc_i        = pc0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        chk(name, sb.size(), 0);
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        e.inst = inst;
        e.pc   = pc;
        sb.push_back(e);
    endtask

    // Fetch 0x04 with stall raised as it appears, park 0x08, sit one HOLD cycle.
    task automatic to_hold();
        do_reset(32'h04);
        push(32'h2042_0001, 32'h04);
        start_i = 1'b1;
        repeat (4) tick();
        stall_i = 1'b1;
        repeat (3) tick();
        tick();
        chk("hold_ack_pe", 32'(s_pe), 32'd1);
        tick();
        chk("hold_no_req", 32'(s_req), 32'd0);
        chk("hold_out_valid", 32'(s_valid), 32'd1);
        chk("hold_out_pc", s_pc, 32'h04);
        chk("hold_out_inst", s_inst, 32'h2042_0001);
    endtask

    initial begin
        vecs[0] = '{32'h00, 32'h8C01_0004, 2};
        vecs[1] = '{32'h04, 32'h2042_0001, 3};
        vecs[2] = '{32'h08, 32'hAC02_0008, 3};
        vecs[3] = '{32'h0C, 32'h0022_1820, 1};
        vecs[4] = '{32'h10, 32'h1043_FFFC, 4};
        vecs[5] = '{32'h14, 32'h0800_0000, 2};

        // Reset state
        rst_i = 1'b0; start_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        pc_i = 32'h0; imem_ack_i = 1'b0; imem_data_i = 32'h0;
        @(posedge clk); #1; @(posedge clk); #1;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_pe", 32'(pcEnable_o), 32'd0);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_pc", inst_pc_o, 32'h0);

        // Basic fetch, ack in second request cycle
        do_reset(32'h0);
        push(32'h8C01_0004, 32'h0);
        start_i = 1'b1;
        tick();
        chk("basic_c0_req", 32'(s_req), 32'd0);
        tick();
        chk("basic_c1_req", 32'(s_req), 32'd1);
        chk("basic_c1_addr", s_addr, 32'h0);
        chk("basic_c1_pe", 32'(s_pe), 32'd0);
        tick();
        chk("basic_ack_pe", 32'(s_pe), 32'd1);
        start_i = 1'b0;
        tick();
        chk("basic_valid", 32'(s_valid), 32'd1);
        chk("basic_inst", s_inst, 32'h8C01_0004);
        chk("basic_pc", s_pc, 32'h0);
        tick();
        chk("basic_valid_one_cycle", 32'(s_valid), 32'd0);
        drain("basic_drain");

        // Table-driven stream with mixed ack latencies
        do_reset(32'h0);
        for (int i = 0; i < 6; i++) push(vecs[i].inst, vecs[i].pc);
        pe_total = 0;
        v_total  = 0;
        start_i  = 1'b1;
        for (int c = 0; c < 200 && sb.size() != 0; c++) begin
            tick();
            if (pe_total == 6) start_i = 1'b0;
        end
        chk("stream_drain", sb.size(), 0);
        repeat (3) tick();
        chk("stream_pe_count", pe_total, 6);
        chk("stream_valid_cycles", v_total, 6);

        // Stall with hold buffer, then release
        to_hold();
        push(32'hAC02_0008, 32'h08);
        push(32'h0022_1820, 32'h0C);
        tick();
        chk("hold_no_req_2", 32'(s_req), 32'd0);
        chk("hold_still_pc", s_pc, 32'h04);
        stall_i = 1'b0;
        tick();
        tick();
        chk("release_valid", 32'(s_valid), 32'd1);
        chk("release_pc", s_pc, 32'h08);
        start_i = 1'b0;
        tick();
        chk("resume_req", 32'(s_req), 32'd1);
        chk("resume_addr", s_addr, 32'h0C);
        drain("stall_drain");

        // Flush while waiting for ack
        do_reset(32'h30);
        push(32'hDEAD_0040, 32'h40);
        start_i = 1'b1;
        tick();
        flush_i = 1'b1;
        target  = 32'h40;
        tick();
        chk("fw_flush_pe", 32'(s_pe), 32'd1);
        flush_i = 1'b0;
        tick();
        chk("fw_c2_pe", 32'(s_pe), 32'd0);
        chk("fw_c2_req_held", 32'(s_req), 32'd1);
        chk("fw_c2_addr", s_addr, 32'h30);
        tick();
        chk("fw_dropped_ack_pe", 32'(s_pe), 32'd0);
        tick();
        chk("fw_no_valid", 32'(s_valid), 32'd0);
        start_i = 1'b0;
        tick();
        chk("fw_redirect_req", 32'(s_req), 32'd1);
        chk("fw_redirect_addr", s_addr, 32'h40);
        drain("fw_drain");

        // Flush in the same cycle as the ack
        do_reset(32'h30);
        push(32'hDEAD_0050, 32'h50);
        start_i = 1'b1;
        repeat (3) tick();
        flush_i = 1'b1;
        target  = 32'h50;
        tick();
        chk("fa_pe", 32'(s_pe), 32'd1);
        flush_i = 1'b0;
        tick();
        chk("fa_no_valid", 32'(s_valid), 32'd0);
        start_i = 1'b0;
        tick();
        chk("fa_redirect_addr", s_addr, 32'h50);
        drain("fa_drain");

        // Flush during HOLD: parked 0x08 must never appear
        to_hold();
        flush_i = 1'b1;
        target  = 32'h60;
        tick();
        chk("fh_pe", 32'(s_pe), 32'd1);
        flush_i = 1'b0;
        stall_i = 1'b0;
        start_i = 1'b0;
        tick();
        chk("fh_no_valid", 32'(s_valid), 32'd0);
        tick();
        chk("fh_no_valid_2", 32'(s_valid), 32'd0);
        chk("fh_idle_no_req", 32'(s_req), 32'd0);
        drain("fh_drain");

        // Async reset in the middle of a request
        do_reset(32'h0);
        push(32'h8C01_0004, 32'h0);
        start_i = 1'b1;
        repeat (5) tick();
        #2;
        flush_i = 1'b1;
        rst_i   = 1'b0;
        #1;
        chk("ar_req", 32'(imem_req_o), 32'd0);
        chk("ar_addr", imem_addr_o, 32'h0);
        chk("ar_pe", 32'(pcEnable_o), 32'd0);
        chk("ar_valid", 32'(inst_valid_o), 32'd0);
        chk("ar_inst", inst_o, 32'h0);
        chk("ar_pc", inst_pc_o, 32'h0);
        imem_ack_i  = 1'b0;
        imem_data_i = 32'h0;
        mcnt        = 0;
        flush_i     = 1'b0;
        pc_i        = 32'h40;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        push(32'hDEAD_0040, 32'h40);
        tick();
        tick();
        chk("ar_first_req", 32'(s_req), 32'd1);
        chk("ar_first_addr", s_addr, 32'h40);
        start_i = 1'b0;
        drain("ar_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly downstream of the program counter register: takes the current PC, issues one instruction-memory request at a time, and delivers the returned instruction with its PC to the IF/ID boundary. It tells the PC register when to advance through `pcEnable_o`. It also absorbs downstream stalls in a one-entry hold buffer, and discards in-flight or buffered instructions on a branch flush.

## Interface
- `INST_W`, default 32: instruction width.
- `ADDR_W`, default 32: PC / memory address width.
- `clk_i` in 1: the block's single clock.
- `rst_i` in 1: asynchronous reset, active-low.
- `start_i` in 1: fetch enable; while low, no new request is issued.
- `pc_i` in ADDR_W: current PC, from the PC register output.
- `stall_i` in 1: downstream (ID) stall; output is held while valid.
- `flush_i` in 1: branch/jump taken; kill younger instructions.
- `pcEnable_o` out 1: PC register load enable (PC loads its next-PC input).
- `imem_req_o` out 1: memory request, level, held until ack.
- `imem_addr_o` out ADDR_W: request address, stable while `imem_req_o`=1.
- `imem_ack_i` in 1: request complete; `imem_data_i` is valid in the same cycle.
- `imem_data_i` in INST_W: returned instruction.
- `inst_o` out INST_W: fetched instruction to IF/ID.
- `inst_pc_o` out ADDR_W: PC of `inst_o`.
- `inst_valid_o` out 1: `inst_o`/`inst_pc_o` are valid.

## Operation
- State machine states:
  - IDLE: no request outstanding.
  - REQ: request outstanding.
  - HOLD: returned instruction is parked in the hold buffer.
- Internal registers: `req_addr`, `drop` flag, hold buffer (`hb_valid`, `hb_inst`, `hb_pc`).
- IDLE → REQ: when `start_i`=1 and `flush_i`=0, capture `pc_i` into `req_addr`. Otherwise stay in IDLE.
- `imem_req_o` = (state==REQ); `imem_addr_o` = `req_addr`.
- REQ, `flush_i`=1 without ack: set `drop`.
- REQ with `imem_ack_i`=1:
  - Discard the data if `drop`=1 or `flush_i`=1. Then clear `drop` and go to IDLE.
  - Otherwise the data is "accepted" and `pcEnable_o`=1 this cycle.
  - If `stall_i`=1 and `inst_valid_o`=1, the accepted data goes into the hold buffer and the state goes to HOLD.
  - Otherwise the accepted data goes to the output register and the state goes to IDLE.
- A started request always completes; deasserting `start_i` in REQ does not drop `imem_req_o`.
- HOLD: no request is issued. When `stall_i`=0 or `flush_i`=1, clear the buffer and go to IDLE.
- `pcEnable_o` = (accepted ack) OR `flush_i`. The flush pulse lets the PC load the branch target.
- Output register update, by priority:
  1. `flush_i`: `inst_valid_o`←0 and `hb_valid`←0.
  2. Else if `stall_i`=1 and `inst_valid_o`=1: output held.
  3. Else if `hb_valid`: output←hold buffer, `inst_valid_o`←1, `hb_valid`←0.
  4. Else if accepted ack: output←{`imem_data_i`, `req_addr`}, `inst_valid_o`←1.
  5. Else: `inst_valid_o`←0; data and PC hold their last value.
- No arithmetic is done here; the next PC is computed upstream of the PC register.

## Timing
- Reset (async, `rst_i`=0): state IDLE, `drop`=0, `hb_valid`=0, `req_addr`=0.
- Output values under reset: `inst_o`=0, `inst_pc_o`=0, `inst_valid_o`=0, `imem_req_o`=0, `imem_addr_o`=0, `pcEnable_o`=0.
- Reset mid-request: the request is abandoned; the memory side must also be reset.
- Latency:
  - Cycle 0 (IDLE): capture PC.
  - Cycle 1: `imem_req_o`=1.
  - Ack in cycle k ≥ 1: `inst_valid_o`=1 from cycle k+1.
- Throughput: at best one instruction per 2 cycles (ack, then IDLE capturing the updated PC).
- `pcEnable_o` is combinational and lasts exactly one cycle per accepted ack or flush cycle.
- `flush_i` in the same cycle as an ack: the data is discarded and `pcEnable_o`=1 (from the flush).
- `flush_i` while in HOLD: the buffer is discarded and IDLE is entered next cycle.
- `flush_i` in IDLE: no capture that cycle; the redirected PC is captured the next cycle.

## Test plan
- Basic fetch: start_i=1, pc_i=0x00, memory acks 1 cycle after req with 0x8C010004 → `imem_addr_o`=0x00. `pcEnable_o` pulses in the ack cycle. Next cycle `inst_o`=0x8C010004, `inst_pc_o`=0x00, `inst_valid_o`=1.
- Stream with PC advancing by 4 and ack latency 3 → instructions at 0x00, 0x04, 0x08 in order, each valid one cycle. Exactly one `pcEnable_o` pulse per instruction.
- Stall with hold: inst at 0x04 valid and stall_i=1, ack for 0x08 arrives → no new req while in HOLD, output stays at 0x04. Release the stall → 0x08 appears next cycle, then fetch resumes.
- Flush while waiting: flush_i in a REQ cycle, ack 2 cycles later → the returned data never appears. `pcEnable_o`=1 only in the flush cycle, then a request to the new pc_i (e.g. 0x40) follows.
- Flush with ack same cycle, and flush during HOLD → `inst_valid_o`=0 next cycle, hold buffer empty, no stale instruction delivered.
- Async reset asserted mid-REQ → all outputs 0 immediately. After release with start_i=1, the first request uses the current pc_i.
